// File: rtl/rffe_slave.sv
// MIPI RFFE slave (responder) model for pin-side loopback of the MIPI master.
// Decodes Register-0 Write, Register Write and Register Read sequences and
// holds a 32 x 8 register file.
//
// Output pulse semantics: o_wr_vld and o_par_err are single-clk strobes with
// no back-pressure. o_wr_addr / o_wr_data are valid in the clk where
// o_wr_vld is high and hold their value until the next commit. o_sdata is
// meaningful only while o_sdata_en is high. dbg_state exposes the frame FSM.
module rffe_slave #(
  parameter int         SYNC_STAGES = 2,
  parameter int         REG_NUM     = 32,
  parameter logic [7:0] RST_REG0    = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] i_usid,
  input  logic       i_sclk,
  input  logic       i_sdata,
  output logic       o_sdata,
  output logic       o_sdata_en,
  output logic       o_wr_vld,
  output logic [4:0] o_wr_addr,
  output logic [7:0] o_wr_data,
  output logic       o_par_err,
  output logic       o_busy,
  output logic [2:0] dbg_state
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CMD   = 3'd1;
  localparam logic [2:0] ST_WDATA = 3'd2;
  localparam logic [2:0] ST_PARK  = 3'd3;
  localparam logic [2:0] ST_RPARK = 3'd4;
  localparam logic [2:0] ST_RDATA = 3'd5;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] sdata_sync;
  logic                   sclk_s;
  logic                   sdata_s;
  logic                   sclk_d;
  logic                   sdata_d;
  logic                   sclk_rise;
  logic                   sclk_fall;
  logic                   sdata_rise;
  logic                   sdata_fall;
  logic                   ssc_armed;
  logic                   ssc_done;

  logic [2:0]             state;
  logic [3:0]             bit_cnt;
  logic [11:0]            shift_sr;
  logic [4:0]             addr;
  logic [8:0]             rd_sr;
  logic [7:0]             regs [REG_NUM];

  logic [12:0]            cmd_word;
  logic [3:0]             cmd_sa;
  logic [7:0]             cmd_c;
  logic                   cmd_par_ok;
  logic                   sa_match;
  logic [8:0]             data_word;
  logic                   data_par_ok;

  // Bring the asynchronous pin signals into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync  <= '0;
      sdata_sync <= '0;
    end else begin
      sclk_sync  <= {sclk_sync[SYNC_STAGES-2:0], i_sclk};
      sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], i_sdata};
    end
  end

  assign sclk_s  = sclk_sync[SYNC_STAGES-1];
  assign sdata_s = sdata_sync[SYNC_STAGES-1];

  // Previous synchronized values for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_d  <= 1'b0;
      sdata_d <= 1'b0;
    end else begin
      sclk_d  <= sclk_s;
      sdata_d <= sdata_s;
    end
  end

  assign sclk_rise  = sclk_s & ~sclk_d;
  assign sclk_fall  = ~sclk_s & sclk_d;
  assign sdata_rise = sdata_s & ~sdata_d;
  assign sdata_fall = ~sdata_s & sdata_d;

  // SSC: an SDATA pulse while SCLK stays low. Any SCLK high phase disarms,
  // so data transitions launched around SCLK rise never look like an SSC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ssc_armed <= 1'b0;
    end else if (sclk_s || ssc_done) begin
      ssc_armed <= 1'b0;
    end else if (sdata_rise) begin
      ssc_armed <= 1'b1;
    end
  end

  assign ssc_done = ssc_armed & ~sclk_s & sdata_fall;

  // Frame words as they stand on the final falling edge (new bit appended).
  assign cmd_word    = {shift_sr, sdata_s};
  assign cmd_sa      = cmd_word[12:9];
  assign cmd_c       = cmd_word[8:1];
  assign cmd_par_ok  = ^cmd_word;
  assign sa_match    = (cmd_sa == i_usid) || (cmd_sa == 4'h0);
  assign data_word   = {shift_sr[7:0], sdata_s};
  assign data_par_ok = ^data_word;

  // Frame FSM, register file and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= 4'd0;
      shift_sr   <= 12'd0;
      addr       <= 5'd0;
      rd_sr      <= 9'd0;
      o_sdata    <= 1'b0;
      o_sdata_en <= 1'b0;
      o_wr_vld   <= 1'b0;
      o_wr_addr  <= 5'd0;
      o_wr_data  <= 8'd0;
      o_par_err  <= 1'b0;
      for (int i = 0; i < REG_NUM; i++) begin
        regs[i] <= (i == 0) ? RST_REG0 : 8'h00;
      end
    end else begin
      o_wr_vld  <= 1'b0;
      o_par_err <= 1'b0;
      if (ssc_done) begin
        // A new SSC always restarts the frame; partial writes are dropped.
        state      <= ST_CMD;
        bit_cnt    <= 4'd0;
        o_sdata    <= 1'b0;
        o_sdata_en <= 1'b0;
      end else begin
        case (state)
          ST_CMD: begin
            if (sclk_fall) begin
              shift_sr <= cmd_word[11:0];
              if (bit_cnt == 4'd12) begin
                bit_cnt <= 4'd0;
                if (!cmd_par_ok) begin
                  o_par_err <= 1'b1;
                  state     <= ST_IDLE;
                end else if (!sa_match) begin
                  state <= ST_IDLE;
                end else if (cmd_c[7]) begin
                  regs[0]   <= {1'b0, cmd_c[6:0]};
                  o_wr_vld  <= 1'b1;
                  o_wr_addr <= 5'd0;
                  o_wr_data <= {1'b0, cmd_c[6:0]};
                  state     <= ST_PARK;
                end else if (cmd_c[7:5] == 3'b010) begin
                  addr  <= cmd_c[4:0];
                  state <= ST_WDATA;
                end else if ((cmd_c[7:5] == 3'b011) && (cmd_sa != 4'h0)) begin
                  addr  <= cmd_c[4:0];
                  state <= ST_RPARK;
                end else begin
                  // Broadcast reads and unsupported commands are ignored.
                  state <= ST_IDLE;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          ST_WDATA: begin
            if (sclk_fall) begin
              shift_sr <= cmd_word[11:0];
              if (bit_cnt == 4'd8) begin
                bit_cnt <= 4'd0;
                if (data_par_ok) begin
                  regs[addr] <= data_word[8:1];
                  o_wr_vld   <= 1'b1;
                  o_wr_addr  <= addr;
                  o_wr_data  <= data_word[8:1];
                  state      <= ST_PARK;
                end else begin
                  o_par_err <= 1'b1;
                  state     <= ST_IDLE;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          ST_PARK: begin
            if (sclk_fall) begin
              state <= ST_IDLE;
            end
          end
          ST_RPARK: begin
            // Master parks the bus; capture the read word with odd parity.
            if (sclk_fall) begin
              rd_sr   <= {regs[addr], ~^regs[addr]};
              bit_cnt <= 4'd0;
              state   <= ST_RDATA;
            end
          end
          ST_RDATA: begin
            if (sclk_rise) begin
              if (bit_cnt < 4'd9) begin
                o_sdata_en <= 1'b1;
                o_sdata    <= rd_sr[8];
                rd_sr      <= {rd_sr[7:0], 1'b0};
                bit_cnt    <= bit_cnt + 4'd1;
              end else if (bit_cnt == 4'd9) begin
                // Slave bus park: drive low for one cycle before release.
                o_sdata <= 1'b0;
                bit_cnt <= 4'd10;
              end
            end else if (sclk_fall && (bit_cnt == 4'd10)) begin
              o_sdata_en <= 1'b0;
              bit_cnt    <= 4'd0;
              state      <= ST_IDLE;
            end
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign o_busy    = (state != ST_IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_rffe_slave.sv
// Bench for rffe_slave: a bit-banged RFFE master drives directed frames,
// expected writes / reads / parity errors are queued as frames are issued,
// and monitor processes pop and compare whenever the slave responds.
module tb_rffe_slave;

  logic       clk;
  logic       rst_n;
  logic [3:0] usid;
  logic       m_sclk;
  logic       m_sdata;
  logic       pin_sdata;
  logic       sdata;
  logic       sdata_en;
  logic       wr_vld;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       par_err;
  logic       busy;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [12:0] exp_wr_q[$];
  logic [9:0]  exp_rd_q[$];
  logic [0:0]  exp_pe_q[$];

  logic [12:0] e_wr;
  logic [9:0]  e_rd;
  logic [9:0]  rd_word = '0;
  int          rd_n = 0;
  logic        en_prev = 1'b0;
  logic        en_seen = 1'b0;

  // Open-drain style pin: slave wins while it drives.
  assign pin_sdata = sdata_en ? sdata : m_sdata;

  rffe_slave #(.SYNC_STAGES(2), .REG_NUM(32), .RST_REG0(8'h00)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_usid     (usid),
    .i_sclk     (m_sclk),
    .i_sdata    (pin_sdata),
    .o_sdata    (sdata),
    .o_sdata_en (sdata_en),
    .o_wr_vld   (wr_vld),
    .o_wr_addr  (wr_addr),
    .o_wr_data  (wr_data),
    .o_par_err  (par_err),
    .o_busy     (busy),
    .dbg_state  (dbg_state)
  );

  // Clock and reset: posedges at 5,15,...; stimulus moves on multiples of 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver tasks: master launches data after SCLK rise, slave samples on fall.
  task automatic send_bit(input logic b);
    m_sclk = 1'b1; #20;
    m_sdata = b;   #60;
    m_sclk = 1'b0; #80;
  endtask

  task automatic park_cycle();
    m_sclk = 1'b1; #20;
    m_sdata = 1'b0; #60;
    m_sclk = 1'b0; #80;
  endtask

  task automatic ssc();
    m_sdata = 1'b0; #80;
    m_sdata = 1'b1; #80;
    m_sdata = 1'b0; #80;
  endtask

  task automatic send_cmd(input logic [3:0] sa, input logic [7:0] c, input logic bad);
    logic [12:0] w;
    w = {sa, c, (~^{sa, c}) ^ bad};
    for (int i = 12; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_data(input logic [7:0] d, input logic bad);
    logic [8:0] w;
    w = {d, (~^d) ^ bad};
    for (int i = 8; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic frame_write(input logic [3:0] sa, input logic [7:0] c, input logic with_data,
                             input logic [7:0] d, input logic bad_cmd, input logic bad_dat);
    ssc();
    chk("busy_after_ssc", {31'd0, busy}, 32'd1);
    send_cmd(sa, c, bad_cmd);
    if (with_data) send_data(d, bad_dat);
    park_cycle();
    #100;
    chk("idle_after_write", {31'd0, busy}, 32'd0);
  endtask

  task automatic frame_read(input logic [3:0] sa, input logic [4:0] a);
    ssc();
    chk("busy_after_ssc", {31'd0, busy}, 32'd1);
    send_cmd(sa, {3'b011, a}, 1'b0);
    park_cycle();
    // Nine data bits plus the slave park cycle.
    for (int i = 0; i < 10; i++) begin
      m_sclk = 1'b1; #80;
      m_sclk = 1'b0; #80;
    end
    #20;
    chk("idle_after_read", {31'd0, busy}, 32'd0);
  endtask

  // Capture slave-driven bits where the master would sample them.
  always @(negedge m_sclk) begin
    if (sdata_en) begin
      rd_word = {rd_word[8:0], sdata};
      rd_n++;
    end
  end

  // Scoreboard monitor: compares each DUT response against the queues.
  always @(negedge clk) begin
    if (sdata_en) en_seen = 1'b1;
    if (en_prev && !sdata_en) begin
      if (rst_n) begin
        if (exp_rd_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL rd_unexpected got %0h expected none", rd_word);
        end else begin
          e_rd = exp_rd_q.pop_front();
          chk("rd_len", rd_n, 32'd10);
          chk("rd_bits", {22'd0, rd_word}, {22'd0, e_rd});
        end
      end
      rd_n = 0;
      rd_word = '0;
    end
    en_prev = sdata_en;
    if (rst_n && wr_vld) begin
      if (exp_wr_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL wr_unexpected got %0h/%0h expected none", wr_addr, wr_data);
      end else begin
        e_wr = exp_wr_q.pop_front();
        chk("wr_commit", {19'd0, wr_addr, wr_data}, {19'd0, e_wr});
      end
    end
    if (rst_n && par_err) begin
      n_checks++;
      if (exp_pe_q.size() == 0) begin
        n_errors++;
        $display("FAIL par_err_unexpected got 1 expected 0");
      end else begin
        void'(exp_pe_q.pop_front());
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    usid = 4'h0;
    m_sclk = 1'b0;
    m_sdata = 1'b0;
    #20;
    chk("rst_sdata", {31'd0, sdata}, 32'd0);
    chk("rst_sdata_en", {31'd0, sdata_en}, 32'd0);
    chk("rst_wr_vld", {31'd0, wr_vld}, 32'd0);
    chk("rst_wr_addr", {27'd0, wr_addr}, 32'd0);
    chk("rst_wr_data", {24'd0, wr_data}, 32'd0);
    chk("rst_par_err", {31'd0, par_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    usid = 4'h5;
    #20;
    rst_n = 1'b1;
    #100;

    // Direct write then read back.
    exp_wr_q.push_back({5'h0A, 8'hC3});
    frame_write(4'h5, 8'h4A, 1'b1, 8'hC3, 1'b0, 1'b0);
    exp_rd_q.push_back({8'hC3, 1'b1, 1'b0});
    frame_read(4'h5, 5'h0A);

    // Register-0 write, then read it back.
    exp_wr_q.push_back({5'h00, 8'h25});
    frame_write(4'h5, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0);
    exp_rd_q.push_back({8'h25, 1'b0, 1'b0});
    frame_read(4'h5, 5'h00);

    // Bad data parity: error pulse, no commit.
    exp_pe_q.push_back(1'b1);
    frame_write(4'h5, 8'h43, 1'b1, 8'h55, 1'b0, 1'b1);
    exp_rd_q.push_back({8'h00, 1'b1, 1'b0});
    frame_read(4'h5, 5'h03);

    // Bad command parity: error pulse, data ignored.
    exp_pe_q.push_back(1'b1);
    frame_write(4'h5, 8'h45, 1'b1, 8'h33, 1'b1, 1'b0);

    // Mismatched SA: no response, register unchanged.
    frame_write(4'h7, 8'h4A, 1'b1, 8'h99, 1'b0, 1'b0);
    exp_rd_q.push_back({8'hC3, 1'b1, 1'b0});
    frame_read(4'h5, 5'h0A);

    // Broadcast write commits; broadcast read stays silent.
    exp_wr_q.push_back({5'h01, 8'h7E});
    frame_write(4'h0, 8'h41, 1'b1, 8'h7E, 1'b0, 1'b0);
    en_seen = 1'b0;
    frame_read(4'h0, 5'h01);
    chk("bcast_read_silent", {31'd0, en_seen}, 32'd0);
    exp_rd_q.push_back({8'h7E, 1'b1, 1'b0});
    frame_read(4'h5, 5'h01);

    // SSC after five data bits aborts; only the second write commits.
    ssc();
    send_cmd(4'h5, 8'h44, 1'b0);
    repeat (5) send_bit(1'b1);
    exp_wr_q.push_back({5'h02, 8'h11});
    frame_write(4'h5, 8'h42, 1'b1, 8'h11, 1'b0, 1'b0);
    exp_rd_q.push_back({8'h00, 1'b1, 1'b0});
    frame_read(4'h5, 5'h04);

    // Reset in the middle of a read releases the pin at once.
    ssc();
    send_cmd(4'h5, 8'h6A, 1'b0);
    park_cycle();
    repeat (3) begin
      m_sclk = 1'b1; #80;
      m_sclk = 1'b0; #80;
    end
    m_sclk = 1'b1; #40;
    chk("en_before_reset", {31'd0, sdata_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_sdata_en", {31'd0, sdata_en}, 32'd0);
    chk("rst_mid_sdata", {31'd0, sdata}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    #9;
    m_sclk = 1'b0;
    #100;
    rst_n = 1'b1;
    #100;
    // Register file was cleared by the reset.
    exp_rd_q.push_back({8'h00, 1'b1, 1'b0});
    frame_read(4'h5, 5'h0A);

    #200;
    chk("wr_queue_empty", exp_wr_q.size(), 32'd0);
    chk("rd_queue_empty", exp_rd_q.size(), 32'd0);
    chk("pe_queue_empty", exp_pe_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
